gsau_wb_ctrl: RTL and testbench

Parametrised successor to the GSAU control unit. It tracks destination tags for instructions dispatched to the systolic array and buffers array output rows in an output FIFO. Each tag is paired with ROWS consecutive output rows, and the pairs are emitted to the vector-register writeback port over a valid/ready handshake. The block adds multi-row instructions, credit-style backpressure to the array, flush, and sticky error reporting.

---
 rtl/sys_arr_pkg.sv | 13 +
 rtl/gsau_sync_fifo.sv | 62 ++++++
 rtl/gsau_wb_ctrl.sv | 148 ++++++++++++++
 tb/tb_gsau_wb_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// rtl/sys_arr_pkg.sv - shared types for the GSAU writeback controller
package sys_arr_pkg;

  localparam int TAG_W_DEFAULT = 8;

  typedef logic [TAG_W_DEFAULT-1:0] wb_tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gsau_state_t;

endpackage

// File: rtl/gsau_sync_fifo.sv
// rtl/gsau_sync_fifo.sv - synchronous FIFO with registered occupancy and clear
module gsau_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gsau_wb_ctrl.sv
// rtl/gsau_wb_ctrl.sv - pairs dispatched destination tags with systolic-array
// output rows and streams them to the vector-register writeback port
module gsau_wb_ctrl
  import sys_arr_pkg::*;
#(
  parameter  int DATA_W       = 512,
  parameter  int REG_W        = 8,
  parameter  int TAG_DEPTH    = 8,
  parameter  int OUT_DEPTH    = 4,
  parameter  int ROWS         = 4,
  parameter  int STALL_MARGIN = 2,
  localparam int IW           = $clog2(TAG_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sb_valid,
  output logic              sb_ready,
  input  logic [REG_W-1:0]  sb_vdst,
  input  logic              sa_out_en,
  input  logic [DATA_W-1:0] sa_array_output,
  output logic              sa_out_stall,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_wbdst,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_last,
  input  logic              flush,
  output logic              busy,
  output logic [IW-1:0]     inflight,
  output logic              err_orphan,
  output logic              err_overflow
);

  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int REW = $clog2(TAG_DEPTH * ROWS + ROWS + 1);

  gsau_state_t       state_q;
  logic              rdy_en_q;
  logic [RCW-1:0]    row_cnt_q, row_cnt_d;
  logic [REW-1:0]    rows_exp_q, rows_exp_d;
  logic              err_orphan_q, err_overflow_q;

  logic              tag_full, tag_empty, tag_pop;
  logic [REG_W-1:0]  head_tag;
  logic              out_full, out_empty;
  logic [OCW-1:0]    out_count;
  logic [DATA_W-1:0] out_head;

  logic              disp_fire, wb_fire, is_last;
  logic              row_orphan, row_ovf, row_push;

  // Readiness stays low through reset and comes up one cycle after release.
  assign sb_ready  = rdy_en_q && !tag_full && !flush;
  assign disp_fire = sb_valid && sb_ready;

  assign wb_valid  = !tag_empty && !out_empty;
  assign is_last   = (row_cnt_q == RCW'(ROWS - 1));
  assign wb_last   = wb_valid && is_last;
  assign wb_wbdst  = wb_valid ? (head_tag + REG_W'(row_cnt_q)) : '0;
  assign wb_data   = wb_valid ? out_head : '0;
  assign wb_fire   = wb_valid && wb_ready && !flush;
  assign tag_pop   = wb_fire && is_last;

  assign row_orphan = sa_out_en && !flush && (rows_exp_q == '0) && !disp_fire;
  assign row_ovf    = sa_out_en && !flush && !row_orphan && out_full;
  assign row_push   = sa_out_en && !flush && !row_orphan && !out_full;

  assign sa_out_stall = (out_count >= OCW'(OUT_DEPTH - STALL_MARGIN));
  assign busy         = (state_q == RUN) || !out_empty;
  assign err_orphan   = err_orphan_q;
  assign err_overflow = err_overflow_q;

  always_comb begin
    rows_exp_d = rows_exp_q;
    if (disp_fire) begin
      rows_exp_d = rows_exp_d + REW'(ROWS);
    end
    if (row_push || row_ovf) begin
      rows_exp_d = rows_exp_d - REW'(1);
    end
    row_cnt_d = row_cnt_q;
    if (wb_fire) begin
      row_cnt_d = is_last ? '0 : row_cnt_q + RCW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      rdy_en_q       <= 1'b0;
      row_cnt_q      <= '0;
      rows_exp_q     <= '0;
      err_orphan_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      rdy_en_q       <= 1'b1;
      err_orphan_q   <= err_orphan_q | row_orphan;
      err_overflow_q <= err_overflow_q | row_ovf;
      if (flush) begin
        state_q    <= IDLE;
        row_cnt_q  <= '0;
        rows_exp_q <= '0;
      end else begin
        row_cnt_q  <= row_cnt_d;
        rows_exp_q <= rows_exp_d;
        case (state_q)
          IDLE:    if (disp_fire) state_q <= RUN;
          RUN:     if (tag_pop && !disp_fire && inflight == IW'(1)) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  gsau_sync_fifo #(
    .WIDTH (REG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (flush),
    .push_i  (disp_fire),
    .wdata_i (sb_vdst),
    .pop_i   (tag_pop),
    .rdata_o (head_tag),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (inflight)
  );

  gsau_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (flush),
    .push_i  (row_push),
    .wdata_i (sa_array_output),
    .pop_i   (wb_fire),
    .rdata_o (out_head),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

endmodule

// File: tb/tb_gsau_wb_ctrl.sv
// tb/tb_gsau_wb_ctrl.sv - self-checking bench for gsau_wb_ctrl
module tb_gsau_wb_ctrl;

  localparam int DATA_W       = 512;
  localparam int REG_W        = 8;
  localparam int TAG_DEPTH    = 8;
  localparam int OUT_DEPTH    = 4;
  localparam int ROWS         = 4;
  localparam int STALL_MARGIN = 2;
  localparam int IW           = $clog2(TAG_DEPTH + 1);

  logic              CLK, RST;
  logic              sb_valid, sb_ready;
  logic [REG_W-1:0]  sb_vdst;
  logic              sa_out_en, sa_out_stall;
  logic [DATA_W-1:0] sa_array_output;
  logic              wb_valid, wb_ready, wb_last;
  logic [REG_W-1:0]  wb_wbdst;
  logic [DATA_W-1:0] wb_data;
  logic              flush, busy, err_orphan, err_overflow;
  logic [IW-1:0]     inflight;

  gsau_wb_ctrl #(
    .DATA_W(DATA_W), .REG_W(REG_W), .TAG_DEPTH(TAG_DEPTH),
    .OUT_DEPTH(OUT_DEPTH), .ROWS(ROWS), .STALL_MARGIN(STALL_MARGIN)
  ) dut (
    .CLK(CLK), .RST(RST), .sb_valid(sb_valid), .sb_ready(sb_ready), .sb_vdst(sb_vdst),
    .sa_out_en(sa_out_en), .sa_array_output(sa_array_output), .sa_out_stall(sa_out_stall),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wbdst(wb_wbdst), .wb_data(wb_data),
    .wb_last(wb_last), .flush(flush), .busy(busy), .inflight(inflight),
    .err_orphan(err_orphan), .err_overflow(err_overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: queues of pending tags and buffered rows plus row accounting.
  logic [REG_W-1:0]  m_tags[$];
  logic [DATA_W-1:0] m_rows[$];
  int                m_rexp, m_rcnt;
  bit                m_up, m_orph, m_ovf;

  logic [REG_W-1:0]  beat_dst[$];
  logic [DATA_W-1:0] beat_data[$];
  logic              beat_last[$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    logic ready_e, vld_e, dispf, wbf, full_pre;
    logic [REG_W-1:0] dst_e;
    @(negedge CLK);
    ready_e = m_up && (m_tags.size() < TAG_DEPTH) && !flush;
    vld_e   = (m_tags.size() > 0) && (m_rows.size() > 0);
    if (!RST) begin
      chk("sb_ready", sb_ready, ready_e);
      chk("wb_valid", wb_valid, vld_e);
      if (vld_e) begin
        dst_e = m_tags[0] + REG_W'(m_rcnt);
        chk("wb_wbdst", wb_wbdst, dst_e);
        chk("wb_data", wb_data, m_rows[0]);
        chk("wb_last", wb_last, m_rcnt == ROWS - 1);
      end
      chk("sa_out_stall", sa_out_stall, m_rows.size() >= OUT_DEPTH - STALL_MARGIN);
      chk("busy", busy, (m_tags.size() > 0) || (m_rows.size() > 0));
      chk("inflight", inflight, m_tags.size());
      chk("err_orphan", err_orphan, m_orph);
      chk("err_overflow", err_overflow, m_ovf);
      if (wb_valid && wb_ready && !flush) begin
        beat_dst.push_back(wb_wbdst);
        beat_data.push_back(wb_data);
        beat_last.push_back(wb_last);
      end
    end
    dispf    = sb_valid && ready_e && !RST;
    wbf      = vld_e && wb_ready && !flush && !RST;
    full_pre = (m_rows.size() == OUT_DEPTH);
    @(posedge CLK);
    if (RST) begin
      m_tags.delete(); m_rows.delete();
      m_rexp = 0; m_rcnt = 0; m_up = 0; m_orph = 0; m_ovf = 0;
    end else begin
      m_up = 1;
      if (flush) begin
        m_tags.delete(); m_rows.delete();
        m_rexp = 0; m_rcnt = 0;
      end else begin
        if (wbf) begin
          void'(m_rows.pop_front());
          if (m_rcnt == ROWS - 1) begin
            void'(m_tags.pop_front());
            m_rcnt = 0;
          end else begin
            m_rcnt++;
          end
        end
        if (sa_out_en) begin
          if (m_rexp == 0 && !dispf) begin
            m_orph = 1;
          end else begin
            if (full_pre) m_ovf = 1;
            else m_rows.push_back(sa_array_output);
            m_rexp--;
          end
        end
        if (dispf) begin
          m_tags.push_back(sb_vdst);
          m_rexp += ROWS;
        end
      end
    end
    #1;
  endtask

  task automatic idle_in();
    sb_valid = 0; sa_out_en = 0; wb_ready = 0; flush = 0; RST = 0;
  endtask

  task automatic dispatch(input logic [REG_W-1:0] v);
    sb_valid = 1; sb_vdst = v; step(); sb_valid = 0;
  endtask

  task automatic feed_rows(input int n, input logic rdy);
    wb_ready = rdy;
    for (int i = 0; i < n; i++) begin
      sa_out_en = 1; sa_array_output = rnd_data(); step();
    end
    sa_out_en = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [DATA_W-1:0] d [4];
    logic [REG_W-1:0]  exp_dst;
    idle_in(); RST = 1; sb_vdst = '0; sa_array_output = '0;
    steps(2);
    RST = 0;
    chk("rst_sb_ready", sb_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    step();

    // 1: single instruction, rows streamed straight through.
    beat_dst.delete(); beat_data.delete(); beat_last.delete();
    dispatch(8'h0A);
    wb_ready = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = rnd_data(); sa_out_en = 1; sa_array_output = d[i]; step();
    end
    sa_out_en = 0; steps(3);
    chk("t1_beats", beat_dst.size(), 4);
    for (int i = 0; i < 4 && i < beat_dst.size(); i++) begin
      exp_dst = 8'h0A + 8'(i);
      chk("t1_dst", beat_dst[i], exp_dst);
      chk("t1_data", beat_data[i], d[i]);
      chk("t1_last", beat_last[i], i == 3);
    end
    chk("t1_busy", busy, 1'b0);

    // 2: full output FIFO under backpressure, then drain.
    beat_dst.delete();
    dispatch(8'h30);
    feed_rows(4, 1'b0);
    steps(3);
    chk("t2_stall", sa_out_stall, 1'b1);
    wb_ready = 1; steps(5);
    chk("t2_beats", beat_dst.size(), 4);

    // 3: fill the tag FIFO, ready returns one cycle after a last-beat pop.
    sb_valid = 1;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      sb_vdst = 8'h40 + 8'(i * 4); step();
    end
    chk("t3_full_ready", sb_ready, 1'b0);
    sb_vdst = 8'h90;
    feed_rows(4, 1'b1);
    steps(4);
    sb_valid = 0;
    flush = 1; step(); flush = 0; step();

    // 4: orphan row is sticky through flush, cleared by reset.
    sa_out_en = 1; sa_array_output = rnd_data(); step(); sa_out_en = 0; step();
    chk("t4_orphan", err_orphan, 1'b1);
    flush = 1; step(); flush = 0; step();
    chk("t4_orphan_flush", err_orphan, 1'b1);
    RST = 1; step(); RST = 0; step();
    chk("t4_orphan_rst", err_orphan, 1'b0);

    // 5: destination index wraps.
    beat_dst.delete();
    dispatch(8'hFE);
    feed_rows(4, 1'b1); steps(3);
    chk("t5_beats", beat_dst.size(), 4);
    if (beat_dst.size() == 4) begin
      chk("t5_dst0", beat_dst[0], 8'hFE);
      chk("t5_dst1", beat_dst[1], 8'hFF);
      chk("t5_dst2", beat_dst[2], 8'h00);
      chk("t5_dst3", beat_dst[3], 8'h01);
    end

    // 6: flush with state held and same-cycle traffic.
    dispatch(8'h50); dispatch(8'h60);
    feed_rows(3, 1'b0);
    flush = 1; sb_valid = 1; sb_vdst = 8'h70; sa_out_en = 1; wb_ready = 1; step();
    idle_in();
    chk("t6_busy", busy, 1'b0);
    chk("t6_inflight", inflight, 0);
    chk("t6_wb_valid", wb_valid, 1'b0);
    beat_dst.delete();
    dispatch(8'h20);
    feed_rows(1, 1'b1); step();
    chk("t6_first_dst", beat_dst.size() > 0 ? beat_dst[0] : 8'hXX, 8'h20);
    feed_rows(3, 1'b1); steps(3);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST       = ($urandom_range(0, 399) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      sb_valid  = ($urandom_range(0, 2) == 0);
      sb_vdst   = REG_W'($urandom);
      sa_out_en = (m_rexp > 0) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 30) == 0;
      if (sa_out_stall && $urandom_range(0, 7) != 0) sa_out_en = 0;
      sa_array_output = rnd_data();
      wb_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
